// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg.sv
// Shared pipeline definitions for the core: data-RAM geometry, the memory /
// ALU / format opcode enumerations and the decoded-instruction bundle
// (pipeline_bus_t) that travels between pipeline stages.
// No ports; compile before any file that imports core.
// ----------------------------------------------------------------------------
package core;

    localparam int ADDR_WIDTH = 11;              // word-address width of data RAM
    localparam int DATA_WIDTH = 32;              // data RAM word width
    localparam int DEPTH      = 1 << ADDR_WIDTH; // data RAM depth in words

    // Encodings 9..15 are unused and behave as MEM_NOP.
    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        LB      = 4'd1,
        LH      = 4'd2,
        LW      = 4'd3,
        LBU     = 4'd4,
        LHU     = 4'd5,
        SB      = 4'd6,
        SH      = 4'd7,
        SW      = 4'd8
    } mem_op_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_NOP  = 4'd15
    } alu_op_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        NOP   = 3'd7
    } format_e;

    typedef struct packed {
        mem_op_e     mem_op;
        alu_op_e     alu_op;
        format_e     format;
        logic [4:0]  rd;
        logic        wb_en;
        logic [31:0] pc;
    } pipeline_bus_t;

    // Idle bundle: all-zero except the opcode fields, which read as NOPs.
    localparam pipeline_bus_t BUS_RESET = '{
        mem_op: MEM_NOP,
        alu_op: ALU_NOP,
        format: NOP,
        rd:     5'd0,
        wb_en:  1'b0,
        pc:     32'd0
    };

endpackage

// File: rtl/mem_stage_if.sv
// ----------------------------------------------------------------------------
// mem_stage_if.sv
// Bundles every non-clock signal of mem_stage: the execute-side handshake
// (in_*), the writeback-side handshake (out_*) and the data-RAM port (dmem_*).
// Modports:
//   slave  - the mem_stage view (consumes in_*, out_ready, dmem_rdata)
//   master - the surrounding pipeline / RAM view (the mirror image)
// ----------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int ADDR_WIDTH = core::ADDR_WIDTH,
    parameter int DATA_WIDTH = core::DATA_WIDTH
);
    // execute -> mem
    logic                     in_valid;
    logic                     in_ready;
    core::pipeline_bus_t      in_bus;
    logic [31:0]              in_addr;
    logic [31:0]              in_wdata;
    // mem -> writeback
    logic                     out_valid;
    logic                     out_ready;
    core::pipeline_bus_t      out_bus;
    logic [31:0]              out_data;
    logic                     out_misalign;
    // data RAM port
    logic                     dmem_en;
    logic [3:0]               dmem_we;
    logic [ADDR_WIDTH-1:0]    dmem_addr;
    logic [DATA_WIDTH-1:0]    dmem_wdata;
    logic [DATA_WIDTH-1:0]    dmem_rdata;

    modport slave (
        input  in_valid, in_bus, in_addr, in_wdata, out_ready, dmem_rdata,
        output in_ready, out_valid, out_bus, out_data, out_misalign,
               dmem_en, dmem_we, dmem_addr, dmem_wdata
    );

    modport master (
        output in_valid, in_bus, in_addr, in_wdata, out_ready, dmem_rdata,
        input  in_ready, out_valid, out_bus, out_data, out_misalign,
               dmem_en, dmem_we, dmem_addr, dmem_wdata
    );

endinterface

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage.sv
// Memory-access stage between execute and writeback. Holds one instruction,
// issues loads/stores to a single-port synchronous data RAM and returns
// lane-extracted (sign/zero-extended) load data or the passthrough ALU result.
//
// Ports:
//   clk     - sole clock, rising edge
//   rst     - asynchronous active-high reset
//   mem_if  - mem_stage_if.slave: in_* handshake from execute, out_* handshake
//             to writeback, dmem_* RAM port (dmem_* are combinational from in_*
//             and active only in the accept cycle)
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword /
// word accesses (no RAM access, out_misalign=1, out_data=faulting address).
// Without it out_misalign is constant 0 and the low address bits are simply
// ignored for halfword/word accesses.
// ----------------------------------------------------------------------------
module mem_stage #(
    parameter int ADDR_WIDTH = core::ADDR_WIDTH,
    parameter int DATA_WIDTH = core::DATA_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  mem_if
);
    import core::*;

    typedef enum logic [1:0] {EMPTY, LOAD, FULL} state_e;

    state_e                r_state;
    state_e                w_next_state;
    pipeline_bus_t         r_bus;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_misalign;
    logic [1:0]            r_off;

    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_accept;
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_trap;
    logic                  w_go_load;
    logic [1:0]            w_off;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_off = mem_if.in_addr[1:0];

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        case (mem_if.in_bus.mem_op)
            LB, LH, LW, LBU, LHU: w_is_load  = 1'b1;
            SB, SH, SW:           w_is_store = 1'b1;
            default:              ;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        w_trap = 1'b0;
        case (mem_if.in_bus.mem_op)
            LH, LHU, SH: w_trap = w_off[0];
            LW, SW:      w_trap = |w_off;
            default:     ;
        endcase
    end
`else
    assign w_trap = 1'b0;
`endif

    // Byte enables and lane-replicated store data; halfwords pick their lane
    // with addr[1] only, words ignore the low two bits.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = mem_if.in_wdata;
        case (mem_if.in_bus.mem_op)
            SB: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{mem_if.in_wdata[7:0]}};
            end
            SH: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{mem_if.in_wdata[15:0]}};
            end
            SW:      w_be = 4'b1111;
            default: ;
        endcase
    end

    assign w_accept  = mem_if.in_valid & w_in_ready;
    assign w_go_load = w_is_load & ~w_trap;

    assign mem_if.dmem_en    = w_accept & (w_is_load | w_is_store) & ~w_trap;
    assign mem_if.dmem_we    = (w_accept & w_is_store & ~w_trap) ? w_be : 4'b0000;
    assign mem_if.dmem_addr  = mem_if.in_addr[ADDR_WIDTH+1:2];
    assign mem_if.dmem_wdata = w_wdata;

    // Lane select and extension of the RAM word for the held load.
    function automatic logic [31:0] f_extract(input mem_op_e op,
                                              input logic [1:0] off,
                                              input logic [31:0] word);
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        case (off)
            2'd0:    v_byte = word[7:0];
            2'd1:    v_byte = word[15:8];
            2'd2:    v_byte = word[23:16];
            default: v_byte = word[31:24];
        endcase
        v_half = off[1] ? word[31:16] : word[15:0];
        case (op)
            LB:      return {{24{v_byte[7]}}, v_byte};
            LBU:     return {24'd0, v_byte};
            LH:      return {{16{v_half[15]}}, v_half};
            LHU:     return {16'd0, v_half};
            default: return word;
        endcase
    endfunction

    assign w_load_data = f_extract(r_bus.mem_op, r_off, mem_if.dmem_rdata);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY: if (w_accept) w_next_state = w_go_load ? LOAD : FULL;
            LOAD:  w_next_state = FULL;
            FULL: begin
                if (mem_if.out_ready) begin
                    if (w_accept) w_next_state = w_go_load ? LOAD : FULL;
                    else          w_next_state = EMPTY;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            EMPTY: w_in_ready = 1'b1;
            FULL: begin
                w_in_ready  = mem_if.out_ready;
                w_out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_if.in_ready  = w_in_ready;
    assign mem_if.out_valid = w_out_valid;

    // Result registers. A load leaves r_data untouched at accept and fills it
    // from the RAM in the LOAD cycle; everything else is final at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus      <= BUS_RESET;
            r_data     <= '0;
            r_misalign <= 1'b0;
            r_off      <= 2'b00;
        end else if (w_accept) begin
            r_bus      <= mem_if.in_bus;
            r_off      <= w_off;
            r_misalign <= w_trap;
            if (!w_go_load)
                r_data <= (w_is_store & ~w_trap) ? '0 : mem_if.in_addr;
        end else if (r_state == LOAD) begin
            r_data <= w_load_data;
        end
    end

    assign mem_if.out_bus      = r_bus;
    assign mem_if.out_data     = r_data;
    assign mem_if.out_misalign = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage.sv
// Directed bench for mem_stage. A behavioural synchronous RAM answers the
// dmem port; each accepted instruction pushes its expected result onto a
// scoreboard queue that a negedge monitor pops when writeback takes a result.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_mem_stage;
    import core::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_stage_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) mif ();

    mem_stage #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_if (mif)
    );

    // ---------------- data RAM model ----------------
    logic [31:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (mif.dmem_en) begin
            if (mif.dmem_we == 4'b0000) begin
                mif.dmem_rdata <= ram[mif.dmem_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mif.dmem_we[b]) ram[mif.dmem_addr][b*8 +: 8] <= mif.dmem_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stray = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]   data;
        logic          mis;
        pipeline_bus_t bus;
        int            acc;
        int            lat;   // 0 = latency not checked
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logic        last_en;
    logic [3:0]  last_we;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    int          last_waits;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (mif.dmem_en && !(mif.in_valid && mif.in_ready)) stray++;
            if (mif.out_valid && mif.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", 64'(mif.out_valid), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("out_data", 64'(mif.out_data), 64'(mon_e.data));
                    chk("out_misalign", 64'(mif.out_misalign), 64'(mon_e.mis));
                    chk("out_bus", 64'(mif.out_bus), 64'(mon_e.bus));
                    if (mon_e.lat > 0) chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called 1 ns after a rising edge; returns 1 ns after the accepting edge
    // with in_valid still high so that calls can run back-to-back.
    task automatic issue(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_mis, input int exp_lat);
        int   waits;
        exp_t e;
        waits             = 0;
        mif.in_valid      = 1'b1;
        mif.in_bus        = BUS_RESET;
        mif.in_bus.mem_op = op;
        mif.in_bus.rd     = 5'(addr);
        mif.in_bus.pc     = 32'h1000 + addr;
        mif.in_addr       = addr;
        mif.in_wdata      = wdata;
        @(negedge clk);
        while (!mif.in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        chk("accept", 64'(mif.in_ready), 64'd1);
        last_en    = mif.dmem_en;
        last_we    = mif.dmem_we;
        last_addr  = 32'(mif.dmem_addr);
        last_wdata = mif.dmem_wdata;
        last_waits = waits;
        e.data = exp_data;
        e.mis  = exp_mis;
        e.bus  = mif.in_bus;
        e.acc  = cyc;
        e.lat  = exp_lat;
        if (mif.in_ready) sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mif.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 64'(sb_q.size()), 64'd0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        mif.in_valid   = 1'b0;
        mif.in_bus     = BUS_RESET;
        mif.in_addr    = 32'd0;
        mif.in_wdata   = 32'd0;
        mif.out_ready  = 1'b1;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(mif.out_valid), 64'd0);
        chk("rst_out_data", 64'(mif.out_data), 64'd0);
        chk("rst_out_misalign", 64'(mif.out_misalign), 64'd0);
        chk("rst_out_bus", 64'(mif.out_bus), 64'(BUS_RESET));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(mif.in_ready), 64'd1);
        @(posedge clk); #1;

        // SW then LW at 0x10.
        issue(SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        chk("sw_en", 64'(last_en), 64'd1);
        chk("sw_we", 64'(last_we), 64'hF);
        chk("sw_addr", 64'(last_addr), 64'd4);
        chk("sw_wdata", 64'(last_wdata), 64'hDEADBEEF);
        issue(LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        chk("lw_we", 64'(last_we), 64'd0);
        chk("lw_en", 64'(last_en), 64'd1);

        // SB 0x13 then signed / unsigned byte loads.
        issue(SB, 32'h13, 32'h00000080, 32'h0, 1'b0, 1);
        chk("sb_we", 64'(last_we), 64'b1000);
        chk("sb_wdata", 64'(last_wdata), 64'h80808080);
        chk("sb_waits_after_load", 64'(last_waits), 64'd1);
        issue(LB, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        issue(LBU, 32'h13, 32'h0, 32'h00000080, 1'b0, 2);

        // Halfword loads from 0x80011234.
        issue(SW, 32'h10, 32'h80011234, 32'h0, 1'b0, 1);
        issue(LH, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 2);
        issue(LHU, 32'h12, 32'h0, 32'h00008001, 1'b0, 2);
        issue(LH, 32'h10, 32'h0, 32'h00001234, 1'b0, 2);

        // SH to the upper half.
        issue(SH, 32'h12, 32'h0000A5A5, 32'h0, 1'b0, 1);
        chk("sh_we", 64'(last_we), 64'b1100);
        chk("sh_wdata", 64'(last_wdata), 64'hA5A5A5A5);
        issue(LW, 32'h10, 32'h0, 32'hA5A51234, 1'b0, 2);

        // Upper address bits are ignored: 0x2010 aliases word 4.
        issue(SW, 32'h2010, 32'h12345678, 32'h0, 1'b0, 1);
        chk("wrap_addr", 64'(last_addr), 64'd4);
        issue(LW, 32'h10, 32'h0, 32'h12345678, 1'b0, 2);

        // Unused encoding behaves as MEM_NOP.
        issue(mem_op_e'(4'd9), 32'h77, 32'h0, 32'h77, 1'b0, 1);
        chk("op9_no_en", 64'(last_en), 64'd0);
        idle();
        wait_drain();

        // Stall: NOP 0x55 held for 3 cycles with another NOP waiting.
        mif.out_ready = 1'b0;
        issue(MEM_NOP, 32'h55, 32'h0, 32'h55, 1'b0, 0);
        mif.in_addr = 32'h66;
        repeat (3) begin
            @(negedge clk);
            chk("stall_out_valid", 64'(mif.out_valid), 64'd1);
            chk("stall_out_data", 64'(mif.out_data), 64'h55);
            chk("stall_in_ready", 64'(mif.in_ready), 64'd0);
            chk("stall_dmem_en", 64'(mif.dmem_en), 64'd0);
            @(posedge clk); #1;
        end
        mif.out_ready = 1'b1;
        issue(MEM_NOP, 32'h66, 32'h0, 32'h66, 1'b0, 1);
        chk("b2b_waits_0", 64'(last_waits), 64'd0);
        issue(MEM_NOP, 32'h67, 32'h0, 32'h67, 1'b0, 1);
        chk("b2b_waits_1", 64'(last_waits), 64'd0);
        issue(MEM_NOP, 32'h68, 32'h0, 32'h68, 1'b0, 1);
        chk("b2b_waits_2", 64'(last_waits), 64'd0);
        idle();
        wait_drain();

        // Misaligned accesses.
`ifdef MEM_MISALIGN_TRAP_EN
        issue(LW, 32'h11, 32'h0, 32'h11, 1'b1, 1);
        chk("mis_lw_no_en", 64'(last_en), 64'd0);
        issue(LH, 32'h13, 32'h0, 32'h13, 1'b1, 1);
        chk("mis_lh_no_en", 64'(last_en), 64'd0);
`else
        issue(LW, 32'h11, 32'h0, 32'h12345678, 1'b0, 2);
        chk("mis_lw_en", 64'(last_en), 64'd1);
        chk("mis_lw_addr", 64'(last_addr), 64'd4);
        issue(LH, 32'h13, 32'h0, 32'h00001234, 1'b0, 2);
`endif
        idle();
        wait_drain();

        // Reset while a load is in flight.
        mif.in_valid      = 1'b1;
        mif.in_bus        = BUS_RESET;
        mif.in_bus.mem_op = LW;
        mif.in_addr       = 32'h10;
        @(negedge clk);
        chk("rl_accept", 64'(mif.in_ready), 64'd1);
        @(posedge clk); #1;
        idle();
        chk("rl_in_load", 64'(mif.in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("rl_async_out_valid", 64'(mif.out_valid), 64'd0);
        chk("rl_async_out_data", 64'(mif.out_data), 64'd0);
        chk("rl_async_out_bus", 64'(mif.out_bus), 64'(BUS_RESET));
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rl_in_ready", 64'(mif.in_ready), 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk("rl_no_output", 64'(mif.out_valid), 64'd0);
        end
        @(posedge clk); #1;
        issue(MEM_NOP, 32'h99, 32'h0, 32'h99, 1'b0, 1);
        idle();
        wait_drain();

        chk("stray_dmem_en", 64'(stray), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the core pipeline, between execute and writeback. Consumes `core::pipeline_bus_t` plus the execute-stage effective address / ALU result and the store operand. Issues loads and stores to the single-port synchronous data RAM (`core::DEPTH` words of `core::DATA_WIDTH` bits) and returns byte/half/word-extracted load data. Holds one instruction at a time, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `ADDR_WIDTH`, `core::ADDR_WIDTH` (11), word-address width of data RAM
- `DATA_WIDTH`, `core::DATA_WIDTH` (32), data width; only 32 supported

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk` in 1, sole clock, rising edge
- `rst` in 1, asynchronous active-high reset
- `in_valid` in 1, execute offers an instruction
- `in_ready` out 1, stage accepts this cycle
- `in_bus` in `core::pipeline_bus_t`, decoded instruction bundle
- `in_addr` in 32, ALU result: effective address for loads/stores, result otherwise
- `in_wdata` in 32, store operand (rs2 value)
- `out_valid` out 1, result available to writeback
- `out_ready` in 1, writeback takes the result
- `out_bus` out `core::pipeline_bus_t`, registered copy of accepted `in_bus`
- `out_data` out 32, load result, or passthrough `in_addr`
- `out_misalign` out 1, misaligned-access flag; constant 0 without macro
- `dmem_en` out 1, RAM access strobe
- `dmem_we` out 4, byte write enables; 0 for reads
- `dmem_addr` out ADDR_WIDTH, word address `in_addr[ADDR_WIDTH+1:2]`
- `dmem_wdata` out 32, lane-replicated store data
- `dmem_rdata` in 32, read data, valid the cycle after `dmem_en` with `dmem_we`==0

## Operation
- Accept = `in_valid & in_ready`. Dmem outputs are combinational from `in_*` and asserted only in the accept cycle.
- Classes:
  - Load: LB/LH/LW/LBU/LHU.
  - Store: SB/SH/SW.
  - Other: MEM_NOP, plus unused encodings 9–15, which are treated as MEM_NOP.
- FSM states EMPTY, LOAD, FULL:
  - EMPTY: `in_ready`=1. On accept:
    - load → LOAD
    - store or other → FULL
  - LOAD: `in_ready`=0, `out_valid`=0. Captures extracted `dmem_rdata` into `out_data` → FULL.
  - FULL: `out_valid`=1, `in_ready`=`out_ready`. On `out_ready`, an accept follows the EMPTY rules; with no accept → EMPTY.
- Store byte enables, by `addr[1:0]`:
  - SB: `4'b0001<<off`
  - SH: `4'b0011<<{off[1],0}`
  - SW: `4'hF`
- Store write data: SB replicates byte ×4; SH replicates half ×2. A store commits in its accept cycle.
- `out_data` per class:
  - Store: 0.
  - Other: `in_addr`.
  - Load: the selected lane, shifted to bit 0. LB/LH sign-extend; LBU/LHU zero-extend.
- Address bits above ADDR_WIDTH+1 are ignored; addresses wrap modulo DEPTH words.
- Misaligned access:
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.

## Timing
- Other/store: accept in cycle N → `out_valid` in N+1.
- Load: accept in N → RAM read in N → `out_valid` in N+2.
- Throughput: 1 per cycle for non-loads under `out_ready`=1; 1 per 2 cycles for loads.
- `out_bus`, `out_data` and `out_misalign` stay stable while `out_valid & !out_ready`. No `dmem_en` while stalled.
- Reset values:
  - State EMPTY, `out_valid`=0, `out_data`=0, `out_misalign`=0.
  - `out_bus`=0 except `mem_op`=MEM_NOP, `alu_op`=ALU_NOP, `format`=NOP.
  - `in_ready`=1 once reset is released.
- Reset during LOAD: pending read is discarded and no output is produced. An already-committed store is not undone.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A misaligned load/store asserts no `dmem_en`.
  - It goes directly to FULL with `out_misalign`=1 and `out_data`=`in_addr` (faulting address). Latency N+1.
- Not defined:
  - `out_misalign` is tied to 0.
  - Halfword ops use only `addr[1]`; word ops ignore `addr[1:0]`.
  - The access proceeds normally on the aligned word/half.

## Test plan
- SW `in_addr`=0x10, `in_wdata`=0xDEADBEEF → `dmem_we`=4'hF, `dmem_addr`=4. Then LW 0x10 → `out_data`=0xDEADBEEF at accept+2.
- SB 0x13, `in_wdata`=0x80 → `dmem_we`=4'b1000, `dmem_wdata`=0x80808080. Then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080.
- Word 0x80011234 at 0x10: LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001; LH 0x10 → 0x00001234.
- MEM_NOP with `in_addr`=0x55, `out_ready` low for 3 cycles:
  - `out_data`=0x55 and stays stable.
  - `in_ready`=0 and no `dmem_en` during the stall.
  - After release: back-to-back accepts every cycle.
- LW at 0x11:
  - Macro defined: `out_misalign`=1, `dmem_en` never high, `out_data`=0x11.
  - Macro undefined: reads word 4.
- Assert `rst` in the LOAD cycle → `out_valid`=0 asynchronously; after release, state EMPTY and `in_ready`=1.
